// File: rtl/cmd_sequencer.sv
// Queued command sequencer: FIFO of (command, argument) pairs feeding a single-step
// run engine with microsecond delays, a per-command watchdog and sticky error flags.
module cmd_sequencer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CMD_BITS   = 4,
    parameter int unsigned ARG_WIDTH  = 8,
    parameter int unsigned STATE_BITS = 4,
    parameter int unsigned DELAY_BITS = 12,
    parameter int unsigned CLK_MHZ    = 24,
    parameter int unsigned TIMEOUT_US = 0
) (
    input  logic                      osc,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [CMD_BITS-1:0]       push_nr,
    input  logic [ARG_WIDTH-1:0]      push_arg,
    input  logic                      flush,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      busy,
    output logic                      step,
    output logic [CMD_BITS-1:0]       cmd_nr,
    output logic [ARG_WIDTH-1:0]      cmd_arg,
    output logic [STATE_BITS-1:0]     cmd_state,
    input  logic                      state_set,
    input  logic [STATE_BITS-1:0]     state_next,
    input  logic                      delay_set,
    input  logic [DELAY_BITS-1:0]     delay_us,
    input  logic                      finish,
    input  logic                      clr_sticky,
    output logic                      ovf,
    output logic                      tmo
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned PRE_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam int unsigned WD_W  = (TIMEOUT_US > 1) ? $clog2(TIMEOUT_US) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_MHZ - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = (TIMEOUT_US > 0) ? WD_W'(TIMEOUT_US - 1) : '0;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t state_q, state_d;

    logic [CMD_BITS-1:0]   mem_nr  [DEPTH];
    logic [ARG_WIDTH-1:0]  mem_arg [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [LVL_W-1:0]      count;

    logic [DELAY_BITS-1:0] us_cnt;
    logic [PRE_W-1:0]      us_pre;
    logic [WD_W-1:0]       wd_cnt;
    logic [PRE_W-1:0]      wd_pre;

    logic fifo_full;
    logic do_push;
    logic do_pop;
    logic do_finish;
    logic wd_expire;
    logic delay_load;

    assign fifo_full  = (count == LVL_W'(DEPTH));
    assign do_push    = push && !flush && !fifo_full;
    assign do_pop     = (state_q == S_IDLE) && (count != '0) && !flush;
    assign do_finish  = step && finish;
    assign delay_load = step && delay_set && !finish && (delay_us != '0);

    // Abort on the edge where the watchdog would reach TIMEOUT_US, so a command
    // stays busy for exactly TIMEOUT_US * CLK_MHZ cycles.
    assign wd_expire  = (TIMEOUT_US != 0) && (state_q == S_RUN) &&
                        (wd_pre == '0) && (wd_cnt == WD_LAST);

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (do_pop) state_d = S_RUN;
            S_RUN:   if (do_finish || wd_expire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == S_RUN);
        step  = busy && (us_cnt == '0);
        full  = fifo_full;
        level = count;
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge osc) begin
        if (do_push) begin
            mem_nr[wr_ptr]  <= push_nr;
            mem_arg[wr_ptr] <= push_arg;
        end
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            cmd_nr    <= '0;
            cmd_arg   <= '0;
            cmd_state <= '0;
            us_cnt    <= '0;
            us_pre    <= '0;
            wd_cnt    <= '0;
            wd_pre    <= '0;
        end else if (do_pop) begin
            cmd_nr    <= mem_nr[rd_ptr];
            cmd_arg   <= mem_arg[rd_ptr];
            cmd_state <= '0;
            us_cnt    <= '0;
            us_pre    <= '0;
            wd_cnt    <= '0;
            wd_pre    <= PRE_LAST;
        end else if (do_finish || wd_expire) begin
            cmd_state <= '0;
            us_cnt    <= '0;
            us_pre    <= '0;
            wd_cnt    <= '0;
            wd_pre    <= '0;
        end else if (state_q == S_RUN) begin
            if (step && state_set) cmd_state <= state_next;

            if (delay_load) begin
                us_cnt <= delay_us;
                us_pre <= PRE_LAST;
            end else if (us_cnt != '0) begin
                if (us_pre == '0) begin
                    us_pre <= PRE_LAST;
                    us_cnt <= us_cnt - DELAY_BITS'(1);
                end else begin
                    us_pre <= us_pre - PRE_W'(1);
                end
            end

            if (wd_pre == '0) begin
                wd_pre <= PRE_LAST;
                wd_cnt <= wd_cnt + WD_W'(1);
            end else begin
                wd_pre <= wd_pre - PRE_W'(1);
            end
        end
    end

    // A set event in the same cycle as clr_sticky keeps the flag high.
    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            tmo <= 1'b0;
        end else begin
            if (push && fifo_full && !flush) ovf <= 1'b1;
            else if (clr_sticky)             ovf <= 1'b0;

            if (wd_expire && !do_finish)     tmo <= 1'b1;
            else if (clr_sticky)             tmo <= 1'b0;
        end
    end

endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Parametrised successor to the bottom-half single-command run/finish/delay machinery. Adds a queued command FIFO, per-command argument, microsecond delays derived from a configurable clock, a watchdog timeout, and sticky error flags.
- Sits between the write-decode section and the payload state machines of a bottom-half design, entirely in the osc domain.
- The host pushes commands. The sequencer pops them one at a time and gates payload progress with a single step qualifier.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- CMD_BITS, 4, command number width
- ARG_WIDTH, 8, per-command argument width
- STATE_BITS, 4, command sub-state width
- DELAY_BITS, 12, width of microsecond delay request (max 4095 us)
- CLK_MHZ, 24, osc frequency in MHz (>=1)
- TIMEOUT_US, 0, watchdog limit per command in us; 0 disables

Ports:
- osc  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- push  in  1  enqueue strobe, one entry per high cycle
- push_nr  in  CMD_BITS  command number to enqueue
- push_arg  in  ARG_WIDTH  argument to enqueue
- flush  in  1  discard all queued (not running) entries
- full  out  1  FIFO holds DEPTH entries
- level  out  clog2(DEPTH)+1  queued entry count, excluding the running command
- busy  out  1  a command is active (RUN state)
- step  out  1  payload may act this cycle
- cmd_nr  out  CMD_BITS  active command number
- cmd_arg  out  ARG_WIDTH  active command argument
- cmd_state  out  STATE_BITS  active command sub-state
- state_set  in  1  load cmd_state from state_next (honoured only when step=1)
- state_next  in  STATE_BITS  new sub-state
- delay_set  in  1  start delay (honoured only when step=1)
- delay_us  in  DELAY_BITS  delay length in us
- finish  in  1  end active command (honoured only when step=1)
- clr_sticky  in  1  clear ovf and tmo flags
- ovf  out  1  sticky: push dropped because FIFO was full
- tmo  out  1  sticky: command aborted by watchdog

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, engine IDLE, delay and watchdog counters zero.
  - Every output is 0 except level=0 and full=0.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo DEPTH.
  - A push while full (full evaluated before the edge) is dropped and sets ovf. This applies even if a pop occurs in the same cycle.
  - flush empties the FIFO; a push in the same cycle is discarded without setting ovf.
  - A flush has no effect on the running command.
- Engine states:
  - IDLE: when level!=0 and flush=0, pop the head, latch cmd_nr/cmd_arg, set cmd_state=0, go to RUN.
  - RUN: busy=1.
- step (combinational): step = busy && us_cnt==0.
- Latency:
  - A push at edge t into an empty FIFO with IDLE engine gives level=1 after t and step=1 after edge t+1.
  - After finish at edge t, the engine is IDLE after t; the next queued command's step is high after t+1, leaving one dead cycle.
- Delay:
  - delay_set with N>0 loads us_cnt=N and prescaler=CLK_MHZ-1.
  - Each cycle with us_cnt!=0: if prescaler==0, reload it and decrement us_cnt; otherwise decrement the prescaler.
  - step is low for exactly N*CLK_MHZ cycles after the edge.
  - N=0 has no effect.
- Same-cycle priority when step=1:
  - finish overrides state_set and delay_set.
  - state_set and delay_set may combine.
- finish: go to IDLE; clear cmd_state, us_cnt and the watchdog. cmd_nr/cmd_arg hold their last values.
- Watchdog (TIMEOUT_US>0):
  - Separate microsecond prescaler and counter, cleared on entering RUN.
  - When the counter reaches TIMEOUT_US: abort to IDLE, clear cmd_state and us_cnt, set tmo.
  - A finish in the same cycle takes precedence; tmo is not set.
- Sticky flags: a set event in the same cycle as clr_sticky wins (flag stays 1).
- Reset mid-command: immediate return to the reset state; queued entries are lost.

Test Plan:
- Push (nr=3, arg=0x5A) into an idle sequencer -> level=1 for one cycle; then busy=1, step=1, cmd_nr=3, cmd_arg=0x5A, cmd_state=0 two cycles after the push.
- In RUN, with CLK_MHZ=24, pulse delay_set with delay_us=2 -> step=0 for exactly 48 cycles, then 1; state_set in the same cycle -> cmd_state updated.
- Push DEPTH+1 entries back-to-back while the first command is running -> full=1 after DEPTH pushes; last push dropped; ovf=1; level=DEPTH. Apply clr_sticky -> ovf=0.
- Queue 3 commands and finish each at its first step -> commands execute in FIFO order, one dead cycle between them, and the pointers wrap correctly over 2*DEPTH pushes.
- With TIMEOUT_US=10 and a command that never finishes -> abort after 240 cycles: busy=0, tmo=1. Repeat with finish in the abort cycle -> tmo=0.
- Drop rst_n mid-delay with 2 entries queued -> all outputs 0 immediately, level=0. After release, a new push runs normally.
